picmicro_pc_stack_unit: RTL



---
 rtl/picmicro_pc_stack_unit_pkg.sv | 21 ++
 rtl/picmicro_return_stack.sv | 60 ++++++
 rtl/picmicro_pc_stack_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/picmicro_pc_stack_unit_pkg.sv
// Shared definitions for the midrange PC / return-stack unit:
// default geometry, reset and interrupt vectors, and the pc_op encoding.
package picmicro_pc_stack_unit_pkg;

   localparam int              PC_WIDTH_DEF     = 13;
   localparam int              STACK_DEPTH_DEF  = 8;
   localparam logic [12:0]     RESET_VECTOR_DEF = 13'h0000;
   localparam logic [12:0]     INT_VECTOR_DEF   = 13'h0004;

   typedef enum logic [2:0] {
      PC_OP_NOP    = 3'd0,
      PC_OP_INC    = 3'd1,
      PC_OP_GOTO   = 3'd2,
      PC_OP_CALL   = 3'd3,
      PC_OP_RETURN = 3'd4,
      PC_OP_PCL_WR = 3'd5,
      PC_OP_INT    = 3'd6,
      PC_OP_RSVD   = 3'd7
   } pc_op_e;

endpackage

// File: rtl/picmicro_return_stack.sv
// Circular hardware return stack with PIC16 wrap semantics: overflow overwrites
// the oldest entry, underflow still pops, and both raise a one-cycle pulse.
module picmicro_return_stack #(
   parameter int PC_WIDTH    = 13,
   parameter int STACK_DEPTH = 8,
   parameter int DEPTH_W     = $clog2(STACK_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [PC_WIDTH-1:0] push_data,
   output logic [PC_WIDTH-1:0] pop_data,
   output logic [DEPTH_W-1:0]  depth,
   output logic                overflow,
   output logic                underflow
);

   localparam int SP_W = $clog2(STACK_DEPTH);

   logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
   logic [SP_W-1:0]     sp;
   logic                full;
   logic                empty;

   assign full     = (depth == DEPTH_W'(STACK_DEPTH));
   assign empty    = (depth == '0);
   // sp always names the next free slot, so the top of stack sits one below it.
   assign pop_data = mem[sp - SP_W'(1)];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the storage is cleared on reset because an underflowing pop
         // returns whatever an entry holds, and that must be a defined zero.
         for (int i = 0; i < STACK_DEPTH; i++) begin
            mem[i] <= '0;
         end
         sp        <= '0;
         depth     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= push && full;
         underflow <= pop && empty;
         if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + SP_W'(1);
            if (!full) begin
               depth <= depth + DEPTH_W'(1);
            end
         end else if (pop) begin
            sp <= sp - SP_W'(1);
            if (!empty) begin
               depth <= depth - DEPTH_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/picmicro_pc_stack_unit.sv
// Program counter and return stack for the midrange core: executes one PC
// operation per op_en strobe and drives the program memory fetch address.
module picmicro_pc_stack_unit
   import picmicro_pc_stack_unit_pkg::*;
#(
   parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
   parameter int                  STACK_DEPTH  = STACK_DEPTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [PC_WIDTH-1:0] INT_VECTOR   = INT_VECTOR_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           op_en,
   input  logic [2:0]                     pc_op,
   input  logic [10:0]                    k_addr,
   input  logic [4:0]                     pclath,
   input  logic [7:0]                     pcl_data,
   output logic [PC_WIDTH-1:0]            pc_out,
   output logic [7:0]                     pcl_out,
   output logic [$clog2(STACK_DEPTH):0]   stk_depth,
   output logic                           stk_overflow,
   output logic                           stk_underflow
);

   pc_op_e              op;
   logic [PC_WIDTH-1:0] pc_plus1;
   logic [PC_WIDTH-1:0] goto_target;
   logic [PC_WIDTH-1:0] pcl_target;
   logic [PC_WIDTH-1:0] pc_next;
   logic [PC_WIDTH-1:0] push_data;
   logic [PC_WIDTH-1:0] pop_data;
   logic                push;
   logic                pop;

   assign op          = pc_op_e'(pc_op);
   assign pc_plus1    = pc_out + PC_WIDTH'(1);
   assign goto_target = PC_WIDTH'({pclath[4:3], k_addr});
   assign pcl_target  = PC_WIDTH'({pclath, pcl_data});
   assign pcl_out     = pc_out[7:0];

   // CALL saves the next instruction; INT saves the one it preempted.
   assign push      = op_en && (op == PC_OP_CALL || op == PC_OP_INT);
   assign pop       = op_en && (op == PC_OP_RETURN);
   assign push_data = (op == PC_OP_INT) ? pc_out : pc_plus1;

   always_comb begin
      // NOTE: defaulting pc_next to the current PC first keeps this purely
      // combinational; any op path that forgets to assign would otherwise
      // leave a latch behind.
      pc_next = pc_out;
      if (op_en) begin
         unique case (op)
            PC_OP_INC:    pc_next = pc_plus1;
            PC_OP_GOTO:   pc_next = goto_target;
            PC_OP_CALL:   pc_next = goto_target;
            PC_OP_RETURN: pc_next = pop_data;
            PC_OP_PCL_WR: pc_next = pcl_target;
            PC_OP_INT:    pc_next = INT_VECTOR;
            default:      pc_next = pc_out;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out <= RESET_VECTOR;
      end else begin
         // NOTE: non-blocking so every register sampled on this edge sees the
         // pre-edge PC, independent of process evaluation order.
         pc_out <= pc_next;
      end
   end

   picmicro_return_stack #(
      .PC_WIDTH    (PC_WIDTH),
      .STACK_DEPTH (STACK_DEPTH),
      .DEPTH_W     ($clog2(STACK_DEPTH) + 1)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .pop_data  (pop_data),
      .depth     (stk_depth),
      .overflow  (stk_overflow),
      .underflow (stk_underflow)
   );

endmodule
